// File: rtl/cam_pkg.sv
// Shared CAM definitions: default geometry, sweep-flush FSM states and the
// match vector type handed to the priority encoder.
package cam_pkg;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int KEY_WIDTH  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

    typedef logic [DEPTH-1:0] match_vec_t;
endpackage

// File: rtl/cam_entry.sv
// One CAM slot: key register, valid bit and exact-match comparator.
// A clear on the same cycle as a write wins over the valid set, but the key still lands.
module cam_entry #(
    parameter int KEY_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [KEY_WIDTH-1:0] wr_key,
    input  logic                 clr_en,
    input  logic [KEY_WIDTH-1:0] cmp_key,
    output logic                 valid,
    output logic                 hit
);
    logic [KEY_WIDTH-1:0] key_q;
    logic [KEY_WIDTH-1:0] key_d;
    logic                 valid_q;
    logic                 valid_d;

    always_comb begin
        key_d   = key_q;
        valid_d = valid_q;
        if (wr_en) begin
            key_d   = wr_key;
            valid_d = 1'b1;
        end
        if (clr_en) begin
            valid_d = 1'b0;
        end
    end

    // Key storage is deliberately left unreset; only the valid bit gates matches.
    always_ff @(posedge clk) begin
        key_q <= key_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;
    assign hit   = valid_q & (key_q == cmp_key);
endmodule

// File: rtl/cam_match_array.sv
// CAM tag store with parallel compare, registered match vector and a
// DEPTH-cycle sweep flush that blocks searches and updates while it runs.
module cam_match_array #(
    parameter int ADDR_WIDTH = cam_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int KEY_WIDTH  = cam_pkg::KEY_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [KEY_WIDTH-1:0]  wr_key,
    input  logic                  inv_en,
    input  logic [ADDR_WIDTH-1:0] inv_addr,
    input  logic                  flush_req,
    output logic                  flush_busy,
    input  logic                  srch_valid,
    input  logic [KEY_WIDTH-1:0]  srch_key,
    output logic                  srch_ready,
    output logic                  match_valid,
    output logic [DEPTH-1:0]      match_vec,
    output logic                  match_any
);
    import cam_pkg::*;

    flush_state_e          state_q;
    flush_state_e          state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;
    logic [DEPTH-1:0]      match_vec_q;
    logic [DEPTH-1:0]      match_vec_d;
    logic                  match_any_q;
    logic                  match_any_d;
    logic                  match_valid_q;
    logic                  match_valid_d;

    logic                  idle;
    logic                  srch_acc;
    logic [DEPTH-1:0]      ent_wr;
    logic [DEPTH-1:0]      ent_clr;
    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_hit;

    assign idle       = (state_q == IDLE);
    assign flush_busy = (state_q == FLUSH);
    // Ready is forced low while reset is asserted, not just after the first edge.
    assign srch_ready = idle & rst_n;
    assign srch_acc   = srch_valid & srch_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign ent_wr[gi]  = wr_en & idle & (wr_addr == ADDR_WIDTH'(gi));
        assign ent_clr[gi] = (inv_en & idle & (inv_addr == ADDR_WIDTH'(gi)))
                           | (flush_busy & (cnt_q == ADDR_WIDTH'(gi)));

        cam_entry #(
            .KEY_WIDTH (KEY_WIDTH)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (ent_wr[gi]),
            .wr_key  (wr_key),
            .clr_en  (ent_clr[gi]),
            .cmp_key (srch_key),
            .valid   (ent_valid[gi]),
            .hit     (ent_hit[gi])
        );
    end

    // Compare uses pre-edge contents, so same-cycle updates are not yet visible.
    always_comb begin
        match_vec_d   = match_vec_q;
        match_any_d   = match_any_q;
        match_valid_d = srch_acc;
        if (srch_acc) begin
            match_vec_d = ent_hit;
            match_any_d = |ent_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_vec_q   <= '0;
            match_any_q   <= 1'b0;
            match_valid_q <= 1'b0;
        end else begin
            match_vec_q   <= match_vec_d;
            match_any_q   <= match_any_d;
            match_valid_q <= match_valid_d;
        end
    end

    assign match_vec   = match_vec_q;
    assign match_any   = match_any_q;
    assign match_valid = match_valid_q;

    logic unused_valid;
    assign unused_valid = ^ent_valid;
endmodule

// File: doc/cam_match_array.md
Name: cam_match_array

Overview:
Tag-storage and parallel-compare stage feeding the CAM priority encoder.
- Holds DEPTH keys, each with a valid bit.
- Compares a search key against all entries and emits a registered DEPTH-bit match vector for the encoder's cam_data_in.
- Supports single-entry write, single-entry invalidate, and a multi-cycle sweep flush.

Parameters:
ADDR_WIDTH, 4, entry index width
DEPTH, 1<<ADDR_WIDTH, number of entries; equals match vector width
KEY_WIDTH, 16, stored/search key width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write wr_key into entry wr_addr, set its valid bit
wr_addr  in  ADDR_WIDTH  write index
wr_key  in  KEY_WIDTH  write data
inv_en  in  1  clear valid bit of entry inv_addr
inv_addr  in  ADDR_WIDTH  invalidate index
flush_req  in  1  start sweep clearing all valid bits
flush_busy  out  1  high while the sweep runs
srch_valid  in  1  search request
srch_key  in  KEY_WIDTH  search key
srch_ready  out  1  search accepted when srch_valid & srch_ready
match_valid  out  1  one-cycle pulse: match_vec updated
match_vec  out  DEPTH  bit i = valid[i] & (key[i]==captured srch_key)
match_any  out  1  |match_vec, registered with match_vec

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all valid bits 0
  - key storage not reset
  - FSM = IDLE, flush counter 0
  - match_vec 0, match_valid 0, match_any 0, flush_busy 0
  - srch_ready 0 during reset
- FSM states:
  - IDLE: srch_ready = 1. flush_req moves to FLUSH and clears counter. Writes, invalidates and searches are all honoured.
  - FLUSH: clear valid[cnt] each cycle, cnt+1. After clearing entry DEPTH-1, go to IDLE. Lasts exactly DEPTH cycles. flush_busy = 1 and srch_ready = 0 throughout.
  - flush_req is ignored while in FLUSH.
- Search latency: 1 cycle. An accepted search at edge N gives match_vec, match_any and match_valid=1 after edge N+1.
  - match_valid deasserts the following cycle unless another search is accepted.
  - match_vec/match_any hold their last value until the next accepted search. They are not cleared by flush.
- Back-to-back searches: one accepted per cycle, full throughput.
- Read-before-write: a search accepted in the same cycle as a write or invalidate compares against pre-update contents. The update is visible to a search accepted the following cycle.
- Write and invalidate to the same address in the same cycle: invalidate wins; the key is still written, valid ends 0. Different addresses: both take effect.
- Write or invalidate during FLUSH: dropped entirely, no key or valid change.
- Duplicate keys: multiple match_vec bits may be set. The downstream encoder selects the lowest index; this block does not deduplicate.
- All-zero key is an ordinary key; only valid entries can match.
- Async reset mid-flush: immediate return to IDLE with all valid bits cleared. Any in-flight match result is discarded (match_valid 0).
- Widths: compare is exact, full KEY_WIDTH. Flush counter is ADDR_WIDTH bits and wraps to 0 on exit.

Decomposition:
- Shared package cam_pkg:
  - ADDR_WIDTH, DEPTH, KEY_WIDTH defaults
  - flush FSM state enum {IDLE, FLUSH}
  - DEPTH-bit match vector typedef shared with the priority encoder
- One sub-module, cam_entry: one key register, valid bit, and equality comparator, with per-entry write/clear enables. cam_match_array generates DEPTH instances, plus the FSM and the output register.

Test Plan:
- Reset, then write key 0x1234 to entry 3; search 0x1234 next cycle -> one cycle later match_valid=1, match_vec=0x0008, match_any=1.
- Write 0xABCD to entries 2 and 9; search 0xABCD -> match_vec=0x0204. Search 0x0000 with no valid entries -> match_vec=0x0000, match_any=0.
- Same-cycle write 0x5555 to entry 5 plus search 0x5555 -> match_vec bit 5 = 0. Repeat search next cycle -> bit 5 = 1.
- Same-cycle wr_en and inv_en at entry 7 (key 0x0F0F); search 0x0F0F -> bit 7 = 0.
- Fill all 16 entries, pulse flush_req:
  - flush_busy high exactly 16 cycles, srch_ready low throughout
  - a write issued mid-flush is dropped
  - after flush, search of any stored key -> match_vec=0x0000
- Assert rst_n=0 at flush cycle 6 -> flush_busy, match_valid and all valid bits 0 immediately. After release, srch_ready=1 and a search of the old key returns 0x0000.
